// File: rtl/log_seq_pkg.sv
// ----------------------------------------------------------------------------
// log_seq_pkg
// Shared types and constants for the log frame sequencer and its result FIFO.
//   seq_state_t : frame controller states
//   sideband_t  : per-argument tag travelling alongside the log unit pipeline
//   result_t    : one tagged log result as stored in the result FIFO
// The index fields are sized for the largest supported frame (2**IDX_MAX_W
// bins). Instances truncate to $clog2(NUM_BINS) at their ports.
// ----------------------------------------------------------------------------
package log_seq_pkg;

    localparam int IDX_MAX_W = 8;
    localparam logic signed [15:0] FLOOR_DEFAULT = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                 valid;
        logic [IDX_MAX_W-1:0] index;
        logic                 last;
        logic                 zero;
    } sideband_t;

    typedef struct packed {
        logic [15:0]          data;
        logic [IDX_MAX_W-1:0] index;
        logic                 last;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// ----------------------------------------------------------------------------
// result_fifo
// Synchronous show-ahead FIFO of result_t. The head entry is visible on
// head_out whenever head_valid_out is high; pop_in consumes it.
// Ports:
//   clk_in, rst_in      clock (rising edge), asynchronous active-low reset
//   push_in/push_data_in write one entry (caller guarantees not full)
//   pop_in              consume the head entry (ignored when empty)
//   head_out            head entry, forced to zero while empty
//   head_valid_out      FIFO not empty
//   count_out           number of stored entries
// ----------------------------------------------------------------------------
module result_fifo
    import log_seq_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push_in,
    input  result_t          push_data_in,
    input  logic             pop_in,
    output result_t          head_out,
    output logic             head_valid_out,
    output logic [CNT_W-1:0] count_out
);

    result_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_pop;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;

    assign w_pop         = pop_in & (r_count != '0);
    assign w_wr_ptr_next = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    // Storage carries no reset; stale contents are masked by the count.
    always_ff @(posedge clk_in) begin
        if (push_in) begin
            r_mem[r_wr_ptr] <= push_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_in) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({push_in, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_valid_out = (r_count != '0);
    assign head_out       = head_valid_out ? r_mem[r_rd_ptr] : '0;
    assign count_out      = r_count;

endmodule

// File: rtl/log_frame_sequencer.sv
// ----------------------------------------------------------------------------
// log_frame_sequencer
// Frame controller around a fixed-latency, non-stallable base-2 log unit.
// Filterbank energies (unsigned 16.16) are issued to the log unit. Each result
// is tagged with its bin index and an end-of-frame flag, then buffered in a
// credit-protected FIFO so downstream back-pressure never loses a result.
// Ports:
//   clk_in, rst_in             clock (rising edge), asynchronous active-low reset
//   enable_in                  permits new frames to start
//   bin_data/valid/last_in,    upstream energy stream
//   bin_ready_out
//   log_arg_out/valid_out      argument to the log unit
//   log_result_in/valid_in     signed 5.11 result from the log unit
//   coef_data/index/last/valid_out, coef_ready_in   downstream result stream
//   frame_done_out             pulse once the last result of a frame is popped
//   frame_err_out              pulse when bin_last_in disagrees with frame length
//   sync_err_out               sticky: result valid misaligned with sideband
// ----------------------------------------------------------------------------
module log_frame_sequencer
    import log_seq_pkg::*;
#(
    parameter  int                 NUM_BINS    = 32,
    parameter  int                 FIFO_DEPTH  = 4,
    parameter  int                 LOG_LATENCY = 1,
    parameter  logic signed [15:0] FLOOR_VALUE = FLOOR_DEFAULT,
    localparam int                 IDX_W       = $clog2(NUM_BINS),
    localparam int                 CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic [31:0]             bin_data_in,
    input  logic                    bin_valid_in,
    input  logic                    bin_last_in,
    output logic                    bin_ready_out,
    output logic [31:0]             log_arg_out,
    output logic                    log_arg_valid_out,
    input  logic [15:0]             log_result_in,
    input  logic                    log_result_valid_in,
    output logic [15:0]             coef_data_out,
    output logic [IDX_W-1:0]        coef_index_out,
    output logic                    coef_last_out,
    output logic                    coef_valid_out,
    input  logic                    coef_ready_in,
    output logic                    frame_done_out,
    output logic                    frame_err_out,
    output logic                    sync_err_out
);

    seq_state_t             r_state;
    logic [IDX_W-1:0]       r_index;
    logic                   r_frame_done;
    logic                   r_frame_err;
    logic                   r_sync_err;
    sideband_t              r_sb [LOG_LATENCY];
    // Masks the alignment check while results issued before a reset may
    // still be emerging from the log unit.
    logic [LOG_LATENCY-1:0] r_guard;

    logic                   w_fire;
    logic                   w_pop;
    logic                   w_at_max;
    logic                   w_end;
    logic                   w_has_credit;
    int                     w_inflight;
    sideband_t              w_sb_new;
    sideband_t              w_sb_tail;
    result_t                w_push_data;
    result_t                w_head;
    logic                   w_head_valid;
    logic [CNT_W-1:0]       w_count;

    // ------------------------------------------------------------------
    // Credits: every accepted bin owns a FIFO slot from issue until pop,
    // so free slots = depth - stored - still inside the log pipeline.
    // Built from registers only, keeping bin_ready_out off any input path.
    // ------------------------------------------------------------------
    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < LOG_LATENCY; i++) begin
            if (r_sb[i].valid) begin
                w_inflight = w_inflight + 1;
            end
        end
        w_has_credit = (FIFO_DEPTH - int'(w_count) - w_inflight) > 0;
    end

    assign bin_ready_out     = (r_state == STREAM) && w_has_credit;
    assign w_fire            = bin_valid_in & bin_ready_out;
    assign log_arg_out       = bin_data_in;
    assign log_arg_valid_out = w_fire;

    assign w_at_max = (r_index == IDX_W'(NUM_BINS - 1));
    assign w_end    = w_fire & (bin_last_in | w_at_max);

    assign w_sb_new = '{
        valid: w_fire,
        index: IDX_MAX_W'(r_index),
        last:  w_end,
        zero:  (bin_data_in == 32'd0)
    };

    // ------------------------------------------------------------------
    // Sideband delay line, one stage per cycle of log unit latency.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < LOG_LATENCY; gi++) begin : g_sb
            always_ff @(posedge clk_in or negedge rst_in) begin
                if (!rst_in) begin
                    r_sb[gi] <= '0;
                end else if (gi == 0) begin
                    r_sb[gi] <= w_sb_new;
                end else begin
                    r_sb[gi] <= r_sb[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign w_sb_tail   = r_sb[LOG_LATENCY-1];
    assign w_push_data = '{
        data:  w_sb_tail.zero ? FLOOR_VALUE : log_result_in,
        index: w_sb_tail.index,
        last:  w_sb_tail.last
    };

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_guard    <= '1;
            r_sync_err <= 1'b0;
        end else begin
            r_guard <= r_guard << 1;
            if (!r_guard[LOG_LATENCY-1] && (log_result_valid_in != w_sb_tail.valid)) begin
                r_sync_err <= 1'b1;
            end
        end
    end

    result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .push_in        (w_sb_tail.valid),
        .push_data_in   (w_push_data),
        .pop_in         (w_pop),
        .head_out       (w_head),
        .head_valid_out (w_head_valid),
        .count_out      (w_count)
    );

    assign w_pop = w_head_valid & coef_ready_in;

    // ------------------------------------------------------------------
    // Frame state machine. A frame is closed by an explicit last beat or
    // by reaching the final bin, whichever comes first, so the index never
    // wraps inside a frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_index      <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_in) begin
                        r_state <= STREAM;
                        r_index <= '0;
                    end
                end
                STREAM: begin
                    if (w_end) begin
                        r_state     <= DRAIN;
                        r_index     <= '0;
                        r_frame_err <= bin_last_in ^ w_at_max;
                    end else if (w_fire) begin
                        r_index <= r_index + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head.last) begin
                        r_frame_done <= 1'b1;
                        r_state      <= enable_in ? STREAM : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign coef_data_out  = w_head.data;
    assign coef_index_out = IDX_W'(w_head.index);
    assign coef_last_out  = w_head.last;
    assign coef_valid_out = w_head_valid;
    assign frame_done_out = r_frame_done;
    assign frame_err_out  = r_frame_err;
    assign sync_err_out   = r_sync_err;

endmodule

// File: tb/tb_log_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_log_frame_sequencer
// Two instances share one stimulus path: dut_a (NUM_BINS=4) for frame,
// floor, length-error, alignment and reset scenarios; dut_b (NUM_BINS=8) for
// back-pressure, where a frame longer than the FIFO makes credits matter.
// A one-cycle log unit model feeds both. Expected results are queued when a
// bin is accepted and compared when the DUT pops a result.
// ----------------------------------------------------------------------------
module tb_log_frame_sequencer;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  i;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en_a, en_b, sel;
    logic [31:0] bin_data;
    logic        bin_valid, bin_last, coef_ready;
    logic        valid_a, valid_b;

    logic [15:0] log_res = 16'h0;
    logic        lv_a = 1'b0, lv_b = 1'b0;
    logic        supp_req = 1'b0, supp_done = 1'b0;

    logic        a_ready, a_arg_v, a_clast, a_cvalid, a_done, a_ferr, a_serr;
    logic [31:0] a_arg;
    logic [15:0] a_cdata;
    logic [1:0]  a_cidx;
    logic        b_ready, b_arg_v, b_clast, b_cvalid, b_done, b_ferr, b_serr;
    logic [31:0] b_arg;
    logic [15:0] b_cdata;
    logic [2:0]  b_cidx;

    logic        m_ready, m_fire, m_cvalid, m_clast, m_done, m_ferr;
    logic [31:0] m_arg;
    logic [15:0] m_cdata;
    logic [2:0]  m_cidx;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_idx  = 0;
    int          fire_cnt = 0, pop_cnt = 0, done_cnt = 0, ferr_cnt = 0;
    exp_t        exp_q[$];
    exp_t        e;
    logic [15:0] got_data[$];
    logic [2:0]  got_idx[$];
    logic        got_last[$];

    assign valid_a = bin_valid & ~sel;
    assign valid_b = bin_valid & sel;

    log_frame_sequencer #(.NUM_BINS(4), .FIFO_DEPTH(4), .LOG_LATENCY(1)) dut_a (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en_a),
        .bin_data_in(bin_data), .bin_valid_in(valid_a), .bin_last_in(bin_last),
        .bin_ready_out(a_ready), .log_arg_out(a_arg), .log_arg_valid_out(a_arg_v),
        .log_result_in(log_res), .log_result_valid_in(lv_a),
        .coef_data_out(a_cdata), .coef_index_out(a_cidx), .coef_last_out(a_clast),
        .coef_valid_out(a_cvalid), .coef_ready_in(coef_ready),
        .frame_done_out(a_done), .frame_err_out(a_ferr), .sync_err_out(a_serr)
    );

    log_frame_sequencer #(.NUM_BINS(8), .FIFO_DEPTH(4), .LOG_LATENCY(1)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .enable_in(en_b),
        .bin_data_in(bin_data), .bin_valid_in(valid_b), .bin_last_in(bin_last),
        .bin_ready_out(b_ready), .log_arg_out(b_arg), .log_arg_valid_out(b_arg_v),
        .log_result_in(log_res), .log_result_valid_in(lv_b),
        .coef_data_out(b_cdata), .coef_index_out(b_cidx), .coef_last_out(b_clast),
        .coef_valid_out(b_cvalid), .coef_ready_in(coef_ready),
        .frame_done_out(b_done), .frame_err_out(b_ferr), .sync_err_out(b_serr)
    );

    assign m_ready  = sel ? b_ready  : a_ready;
    assign m_fire   = sel ? b_arg_v  : a_arg_v;
    assign m_arg    = sel ? b_arg    : a_arg;
    assign m_cvalid = sel ? b_cvalid : a_cvalid;
    assign m_cdata  = sel ? b_cdata  : a_cdata;
    assign m_cidx   = sel ? b_cidx   : {1'b0, a_cidx};
    assign m_clast  = sel ? b_clast  : a_clast;
    assign m_done   = sel ? b_done   : a_done;
    assign m_ferr   = sel ? b_ferr   : a_ferr;

    // Approximate log2 in 5.11: integer part from the MSB position, fraction
    // from the next 11 mantissa bits. log(0) returns a marker the DUT must
    // replace with the floor value.
    function automatic logic [15:0] log_model(input logic [31:0] x);
        int          p;
        logic [31:0] n;
        if (x == 32'd0) return 16'h1234;
        p = 31;
        while (!x[p]) p--;
        n = x << (31 - p);
        return 16'((p - 16) * 2048) + 16'(n[30:20]);
    endfunction

    // Log unit: one-cycle pipeline, not reset. supp_req toggling drops the
    // valid of the next dut_a beat.
    always @(posedge clk) begin
        log_res <= log_model(m_arg);
        lv_b    <= b_arg_v;
        if (a_arg_v && (supp_req != supp_done)) begin
            lv_a      <= 1'b0;
            supp_done <= supp_req;
        end else begin
            lv_a <= a_arg_v;
        end
    end

    // Scoreboard: push on accept, pop and compare on DUT output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_fire) begin
                e.d = (m_arg == 32'd0) ? 16'h8000 : log_model(m_arg);
                e.i = 3'(exp_idx);
                e.l = bin_last || (exp_idx == (sel ? 7 : 3));
                exp_q.push_back(e);
                exp_idx  = e.l ? 0 : exp_idx + 1;
                fire_cnt = fire_cnt + 1;
            end
            if (m_cvalid && coef_ready) begin
                n_checks = n_checks + 1;
                pop_cnt  = pop_cnt + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL pop_unexpected: got data=%h idx=%0d last=%0d, required no output",
                             m_cdata, m_cidx, m_clast);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_cdata, m_cidx, m_clast} !== {e.d, e.i, e.l}) begin
                        n_fail = n_fail + 1;
                        $display("FAIL scoreboard_pop: got data=%h idx=%0d last=%0d, required data=%h idx=%0d last=%0d",
                                 m_cdata, m_cidx, m_clast, e.d, e.i, e.l);
                    end
                end
                got_data.push_back(m_cdata);
                got_idx.push_back(m_cidx);
                got_last.push_back(m_clast);
            end
            if (m_done) done_cnt = done_cnt + 1;
            if (m_ferr) ferr_cnt = ferr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_data.delete();
        got_idx.delete();
        got_last.delete();
    endtask

    task automatic send_bin(input logic [31:0] d, input logic last);
        bit ok = 1'b0;
        bin_data  = d;
        bin_valid = 1'b1;
        bin_last  = last;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        bin_data  = 32'd0;
        n_checks  = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL send_timeout: ready=0 for data %h, required ready within 300 cycles", d);
        end
    endtask

    task automatic wait_drain(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_cvalid) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) tick();
        n_checks = n_checks + 1;
        if (!ok) begin
            n_fail = n_fail + 1;
            $display("FAIL %s_drain: %0d results outstanding, required 0 within 200 cycles", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 1'b0;
        bin_data = 32'd0; bin_valid = 1'b0; bin_last = 1'b0; coef_ready = 1'b1;
        #1;
        repeat (3) tick();
        n_checks = n_checks + 1;
        if ({a_ready, a_arg_v, a_cvalid, a_cdata, a_cidx, a_clast, a_done, a_ferr, a_serr} !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_a: outputs=%b, required all 0",
                     {a_ready, a_arg_v, a_cvalid, a_cdata, a_cidx, a_clast, a_done, a_ferr, a_serr});
        end
        n_checks = n_checks + 1;
        if ({b_ready, b_cvalid, b_cdata, b_cidx, b_done, b_ferr, b_serr} !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_b: outputs=%b, required all 0",
                     {b_ready, b_cvalid, b_cdata, b_cidx, b_done, b_ferr, b_serr});
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_frame();
        logic [15:0] exp_d [4];
        int d0, f0;
        exp_d = '{16'h0000, 16'h0800, 16'h1000, 16'hF800};
        sel = 1'b0; en_a = 1'b1; coef_ready = 1'b1;
        clear_got();
        d0 = done_cnt; f0 = ferr_cnt;
        send_bin(32'h0001_0000, 1'b0);
        send_bin(32'h0002_0000, 1'b0);
        send_bin(32'h0004_0000, 1'b0);
        send_bin(32'h0000_8000, 1'b1);
        wait_drain("frame");
        n_checks = n_checks + 1;
        if (got_data.size() != 4) begin
            n_fail = n_fail + 1;
            $display("FAIL frame_count: got %0d results, required 4", got_data.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks = n_checks + 1;
            if (got_data[i] !== exp_d[i] || got_idx[i] !== 3'(i) || got_last[i] !== (i == 3)) begin
                n_fail = n_fail + 1;
                $display("FAIL frame_beat%0d: got data=%h idx=%0d last=%0d, required data=%h idx=%0d last=%0d",
                         i, got_data[i], got_idx[i], got_last[i], exp_d[i], i, (i == 3));
            end
        end
        n_checks = n_checks + 1;
        if (done_cnt - d0 != 1 || ferr_cnt - f0 != 0 || a_serr !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL frame_flags: done pulses=%0d ferr pulses=%0d sync=%0d, required 1 0 0",
                     done_cnt - d0, ferr_cnt - f0, a_serr);
        end
    endtask

    task automatic test_floor();
        clear_got();
        send_bin(32'h0001_0000, 1'b0);
        send_bin(32'h0002_0000, 1'b0);
        send_bin(32'h0000_0000, 1'b0);
        send_bin(32'h0004_0000, 1'b1);
        wait_drain("floor");
        n_checks = n_checks + 1;
        if (got_data[2] !== 16'h8000 || got_idx[2] !== 3'd2) begin
            n_fail = n_fail + 1;
            $display("FAIL floor_value: got data=%h idx=%0d, required data=8000 idx=2", got_data[2], got_idx[2]);
        end
        n_checks = n_checks + 1;
        if (got_data[1] !== 16'h0800 || got_data[3] !== 16'h1000) begin
            n_fail = n_fail + 1;
            $display("FAIL floor_neighbours: got %h %h, required 0800 1000", got_data[1], got_data[3]);
        end
    endtask

    task automatic test_frame_err();
        int f0;
        clear_got();
        f0 = ferr_cnt;
        send_bin(32'h0003_0000, 1'b0);
        send_bin(32'h0005_0000, 1'b1);
        wait_drain("short");
        n_checks = n_checks + 1;
        if (ferr_cnt - f0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL frame_err_pulse: got %0d pulses, required 1", ferr_cnt - f0);
        end
        n_checks = n_checks + 1;
        if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1 || got_idx[1] !== 3'd1) begin
            n_fail = n_fail + 1;
            $display("FAIL short_last: got last=%0d%0d idx1=%0d, required last=01 idx1=1",
                     got_last[0], got_last[1], got_idx[1]);
        end
        clear_got();
        for (int k = 0; k < 4; k++) send_bin(32'(k + 1) << 16, k == 3);
        wait_drain("after_short");
        n_checks = n_checks + 1;
        if (got_idx[0] !== 3'd0 || got_data.size() != 4 || ferr_cnt - f0 != 1) begin
            n_fail = n_fail + 1;
            $display("FAIL after_short: got idx0=%0d count=%0d ferr=%0d, required 0 4 1",
                     got_idx[0], got_data.size(), ferr_cnt - f0);
        end
    endtask

    task automatic test_backpressure();
        int fc0, d0, f0, bad;
        logic [22:0] snap;
        en_a = 1'b0; sel = 1'b1; en_b = 1'b1; coef_ready = 1'b0;
        clear_got();
        fc0 = fire_cnt; d0 = done_cnt; f0 = ferr_cnt; bad = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) send_bin((32'(k + 1) << 15) + 32'(k * 123), k == 7);
            end
            begin
                repeat (10) @(negedge clk);
                snap = {m_cvalid, m_cdata, m_cidx, m_clast};
                repeat (15) begin
                    @(negedge clk);
                    if ({m_cvalid, m_cdata, m_cidx, m_clast} !== snap) bad = bad + 1;
                end
                n_checks = n_checks + 1;
                if (fire_cnt - fc0 != 4 || m_ready !== 1'b0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL credit_stop: got %0d fires ready=%0d, required 4 fires ready=0",
                             fire_cnt - fc0, m_ready);
                end
                n_checks = n_checks + 1;
                if (snap !== {1'b1, 16'hF800, 3'd0, 1'b0} || bad != 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL hold_stable: head=%h changes=%0d, required head=%h changes=0",
                             snap, bad, {1'b1, 16'hF800, 3'd0, 1'b0});
                end
                @(posedge clk);
                #1 coef_ready = 1'b1;
            end
        join
        wait_drain("backpressure");
        n_checks = n_checks + 1;
        if (got_data.size() != 8 || fire_cnt - fc0 != 8) begin
            n_fail = n_fail + 1;
            $display("FAIL bp_count: got %0d results %0d fires, required 8 8", got_data.size(), fire_cnt - fc0);
        end
        n_checks = n_checks + 1;
        if (done_cnt - d0 != 1 || ferr_cnt - f0 != 0 || b_serr !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL bp_flags: done=%0d ferr=%0d sync=%0d, required 1 0 0",
                     done_cnt - d0, ferr_cnt - f0, b_serr);
        end
        en_b = 1'b0; sel = 1'b0; en_a = 1'b1;
        tick();
    endtask

    task automatic test_sync();
        n_checks = n_checks + 1;
        if (a_serr !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL sync_before: got %0d, required 0", a_serr);
        end
        supp_req = ~supp_req;
        for (int k = 0; k < 4; k++) send_bin(32'h0001_8000 + 32'(k << 14), k == 3);
        wait_drain("sync");
        n_checks = n_checks + 1;
        if (a_serr !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL sync_rise: got %0d, required 1", a_serr);
        end
        repeat (10) tick();
        n_checks = n_checks + 1;
        if (a_serr !== 1'b1) begin
            n_fail = n_fail + 1;
            $display("FAIL sync_sticky: got %0d, required 1", a_serr);
        end
    endtask

    task automatic test_reset_midframe();
        int pc0;
        send_bin(32'h0001_0000, 1'b0);
        send_bin(32'h0002_0000, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_checks = n_checks + 1;
        if ({a_ready, a_arg_v, a_cvalid, a_cdata, a_cidx, a_clast, a_done, a_ferr, a_serr} !== '0) begin
            n_fail = n_fail + 1;
            $display("FAIL reset_mid: outputs=%b, required all 0",
                     {a_ready, a_arg_v, a_cvalid, a_cdata, a_cidx, a_clast, a_done, a_ferr, a_serr});
        end
        exp_q.delete();
        exp_idx = 0;
        #3 rst_n = 1'b1;
        tick();
        clear_got();
        pc0 = pop_cnt;
        for (int k = 0; k < 4; k++) send_bin(32'h0004_0000 >> k, k == 3);
        wait_drain("post_reset");
        n_checks = n_checks + 1;
        if (got_idx[0] !== 3'd0 || pop_cnt - pc0 != 4) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset: got idx0=%0d pops=%0d, required 0 4", got_idx[0], pop_cnt - pc0);
        end
        n_checks = n_checks + 1;
        if (a_serr !== 1'b0) begin
            n_fail = n_fail + 1;
            $display("FAIL post_reset_sync: got %0d, required 0", a_serr);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_floor();
        test_frame_err();
        test_backpressure();
        test_sync();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/log_frame_sequencer.md
Name: log_frame_sequencer

Overview:
- Frame-level controller for the feature extractor's fixed-latency, non-stallable base-2 logarithm unit.
- Accepts filterbank energies (unsigned 16.16), issues them to the log unit, and tags each result with its bin index and an end-of-frame flag.
- Buffers results in a small FIFO under credit-based flow control, so downstream back-pressure never drops a log result.
- Sits between the filterbank stage and the DCT/cepstrum stage.

Parameters:
- NUM_BINS, 32: bins per frame; index width is $clog2(NUM_BINS).
- FIFO_DEPTH, 4: result FIFO entries; this is also the total credit count.
- LOG_LATENCY, 1: cycles from issuing a log argument to its result being valid.
- FLOOR_VALUE, 16'sh8000: output substituted for log(0).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  permits new frames to start.
- bin_data_in  input  32  filterbank energy, unsigned 16.16.
- bin_valid_in  input  1  upstream valid.
- bin_last_in  input  1  marks the final bin of a frame.
- bin_ready_out  output  1  upstream ready.
- log_arg_out  output  32  argument to the log unit.
- log_arg_valid_out  output  1  argument valid.
- log_result_in  input  16  signed log result, 5.11 format.
- log_result_valid_in  input  1  result valid from the log unit.
- coef_data_out  output  16  signed log value.
- coef_index_out  output  $clog2(NUM_BINS)  bin index.
- coef_last_out  output  1  last result of the frame.
- coef_valid_out  output  1  downstream valid.
- coef_ready_in  input  1  downstream ready.
- frame_done_out  output  1  one-cycle pulse when a frame is fully drained.
- frame_err_out  output  1  one-cycle pulse on a frame-length mismatch.
- sync_err_out  output  1  sticky error: result/sideband misalignment.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All outputs go to 0.
  - State goes to IDLE; index, credit and sideband registers clear; FIFO empties.
  - In-flight log results are discarded, and results arriving after reset release are ignored.
- Log unit interface:
  - The log unit is treated as a LOG_LATENCY-deep pipeline with no stall; its ready input is tied high externally.
  - log_arg_out = bin_data_in and log_arg_valid_out = fire, both combinational.
  - fire = bin_valid_in & bin_ready_out.
- Credits:
  - credits = FIFO_DEPTH - fifo_count - inflight.
  - Decrement on fire; increment on FIFO pop (coef_valid_out & coef_ready_in).
  - Fire and pop in the same cycle leave credits unchanged.
  - Credits never go negative, so the FIFO can never overflow.
- bin_ready_out = (state == STREAM) & (credits > 0). It is driven from registers only.
- Sideband:
  - A LOG_LATENCY-stage shift register carries {valid, index, last, zero} alongside each argument.
  - zero = (bin_data_in == 0).
- At the sideband tail:
  - If sideband valid is set, push {zero ? FLOOR_VALUE : log_result_in, index, last} into the FIFO.
  - If log_result_valid_in differs from sideband valid, set sync_err_out. It stays high until reset.
- Latency: a bin accepted in cycle T has its result pushed at the end of cycle T+LOG_LATENCY. It appears on coef_* in cycle T+LOG_LATENCY+1 (show-ahead FIFO). Minimum latency is 2 cycles.
- State machine:
  - IDLE: bin_ready_out = 0. Go to STREAM when enable_in = 1; index resets to 0.
  - STREAM: on each fire, index increments. The frame ends on a fire with bin_last_in = 1 or index = NUM_BINS-1.
    - The ending beat's sideband last = 1.
    - If bin_last_in and (index == NUM_BINS-1) disagree, frame_err_out pulses in the following cycle.
    - Go to DRAIN. Deasserting enable_in mid-frame does not abort; the frame completes.
  - DRAIN: no acceptance. When the FIFO pops the entry with last = 1, frame_done_out pulses in the next cycle. The state then goes to STREAM if enable_in = 1, otherwise to IDLE.
- Index does not wrap inside a frame; the forced end at NUM_BINS-1 guarantees this.
- A full FIFO with coef_ready_in = 0 holds coef_* stable (the valid/ready hold rule).

Decomposition:
- Shared package log_seq_pkg holds:
  - seq_state_t enum {IDLE, STREAM, DRAIN}.
  - sideband_t struct {valid, index, last, zero}.
  - result_t struct {data, index, last}.
  - FLOOR default constant.
- Sub-module: result_fifo, a synchronous show-ahead FIFO of result_t with depth FIFO_DEPTH, a count output, and the same asynchronous active-low reset.

Test Plan:
- Frame, NUM_BINS=4, inputs 0x0001_0000, 0x0002_0000, 0x0004_0000, 0x0000_8000 with bin_last_in on the 4th → coef 0x0000, 0x0800, 0x1000, 0xF800; indices 0-3; coef_last_out only on index 3; frame_done_out pulses once; no errors.
- coef_ready_in held low, 8 bins offered (FIFO_DEPTH=4) → bin_ready_out drops after exactly 4 fires; on release all 8 results appear in order, none lost or duplicated.
- bin_data_in = 0 at index 2 → coef_data_out = 16'sh8000 at index 2; neighbouring bins unaffected.
- bin_last_in at index 1 with NUM_BINS=4 → frame_err_out one pulse; coef_last_out on index 1; next frame starts at index 0.
- log_result_valid_in suppressed for one issued beat → sync_err_out rises and stays 1 until rst_in low.
- rst_in driven low mid-frame between clock edges → all outputs 0 immediately; after release with enable_in = 1, the next accepted bin has index 0 and no stale results emerge.
